sample_resp_misr: RTL and testbench
===================================

# sample_resp_misr

Response-capture stage placed directly downstream of the `sample` combinational logic block. It samples the three outputs `o`, `p`, `q` on qualified cycles for a programmed number of vectors. It compacts them into a multiple-input signature register (MISR) and counts the ones seen on each output. A start/busy/done handshake lets a test sequencer run a capture window and read back one signature per run.

## Interface

Parameters:
- `MISR_W`, 16: signature width, at least 4.
- `TAPS`, 16'hB400: feedback mask. The default polynomial is x^16+x^14+x^13+x^11+1, taps on bits 15, 13, 12 and 10.
- `SEED`, 16'hFFFF: value loaded into the signature when a run starts.
- `CNT_W`, 8: width of `len` and of each ones-counter.

Ports:
- `clk` input 1: single clock; all logic is on the rising edge.
- `ret` input 1: synchronous, active-high reset.
- `start` input 1: run request. Accepted only in IDLE.
- `len` input CNT_W: number of vectors to capture. Sampled when `start` is accepted.
- `in_valid` input 1: `o`/`p`/`q` are valid this cycle.
- `o`, `p`, `q` input 1 each: response bits from the `sample` block.
- `busy` output 1: high in RUN and DONE.
- `done` output 1: one-cycle pulse at end of run.
- `signature` output MISR_W: compacted response.
- `cnt_o`, `cnt_p`, `cnt_q` output CNT_W each: ones counts, saturating.

## Operation

- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `start`=1 loads `signature`<=SEED, clears all counters and sets `remaining`<=`len`.
  - If `len`=0, next state is DONE; otherwise next state is RUN.
  - `start`=0 holds IDLE. All outputs hold their values, so the last result stays readable.
- RUN, on a cycle with `in_valid`=1:
  - fb = XOR-reduce(`signature` & TAPS).
  - `signature` <= {`signature`[MISR_W-2:0], fb} XOR {0…0, `q`, `p`, `o`}. `o` goes into bit 0, `p` into bit 1, `q` into bit 2.
  - Each counter increments when its bit is 1 and saturates at all-ones with no wrap.
  - `remaining` decrements. When `remaining`=1 on a valid cycle, next state is DONE.
- RUN, on a cycle with `in_valid`=0: no state changes. There is no timeout.
- DONE: `done`=1 for exactly this cycle, then the FSM returns to IDLE unconditionally.
- Ignored inputs:
  - `start` in RUN or DONE is ignored; no queuing.
  - `in_valid` outside RUN is ignored.
  - `len` is only sampled at start acceptance.
- Reset (`ret`=1), at any time including mid-run:
  - The FSM goes to IDLE.
  - `signature`=0, `cnt_*`=0, `busy`=0, `done`=0 and `remaining`=0.
  - Reset has priority over `start` and `in_valid` in the same cycle.

## Timing

- `start` is accepted at edge N. `busy` is high from N+1.
- The first capturable vector is the cycle after acceptance.
- The last valid vector is captured at edge M. `done`=1 during cycle M+1, and `busy` drops at M+2.
- `signature` and `cnt_*` are final and stable from the cycle where `done`=1. They hold until the next accepted `start` or `ret`.
- With `len`=0, `done` pulses in the cycle after acceptance. `signature`=SEED and all counts are 0.
- A new `start` is accepted at the earliest on the cycle after `done`, with `busy`=0.
- Minimum run length for `len`=L with continuous `in_valid` is L+2 cycles from acceptance to the return to IDLE.
- No combinational path from inputs to outputs.

## Test plan

- Reset, then idle: all outputs are 0 and `busy`=0. `start` with `len`=0 gives `done` in the next cycle, `signature`=16'hFFFF and counts 0.
- `start` with `len`=1, then one valid vector `o`=1, `p`=0, `q`=1: the `done` pulse shows `signature`=16'hFFFB, `cnt_o`=1, `cnt_p`=0, `cnt_q`=1.
- `len`=2 with vectors {1,0,1} then {0,0,0}, and `in_valid` low for 3 cycles between them: `signature`=16'hFFF6, and `done` appears only after the second valid vector.
- `len`=255 with `o`=`p`=`q`=1 every cycle, then restart with `len`=255: all counts saturate at 8'hFF with no wrap. `start` pulses asserted during RUN are ignored.
- `ret` asserted mid-run after 5 vectors: outputs go to 0 and the FSM to IDLE the next cycle, with no `done`. A fresh run then gives results identical to a run on a clean device.
- `ret` and `start` asserted in the same cycle: reset wins, and `busy` stays 0.

Source files
------------

// File: rtl/sample_resp_misr.sv
// Response capture for the sample block: MISR compaction of o/p/q
// plus saturating ones-counters over a programmed vector window.
module sample_resp_misr #(
  parameter int                MISR_W = 16,
  parameter logic [MISR_W-1:0] TAPS   = 16'hB400,
  parameter logic [MISR_W-1:0] SEED   = 16'hFFFF,
  parameter int                CNT_W  = 8
) (
  input  logic              clk,
  input  logic              ret,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              in_valid,
  input  logic              o,
  input  logic              p,
  input  logic              q,
  output logic              busy,
  output logic              done,
  output logic [MISR_W-1:0] signature,
  output logic [CNT_W-1:0]  cnt_o,
  output logic [CNT_W-1:0]  cnt_p,
  output logic [CNT_W-1:0]  cnt_q
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             nstate;
  logic [CNT_W-1:0]   remaining;
  logic               accept;
  logic               cap;
  logic               fb;
  logic [MISR_W-1:0]  ins;

  assign accept = (state == IDLE) && start;
  assign cap    = (state == RUN) && in_valid;
  assign fb     = ^(signature & TAPS);
  assign ins    = {{(MISR_W-3){1'b0}}, q, p, o};

  always_ff @(posedge clk) begin
    if (ret) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: begin
        if (start)
          nstate = (len == '0) ? DONE : RUN;
      end
      RUN: begin
        if (in_valid && remaining == CNT_W'(1))
          nstate = DONE;
      end
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      IDLE: ;
      RUN:  busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Results are left untouched outside capture so the last run stays readable
  always_ff @(posedge clk) begin
    if (ret) begin
      signature <= '0;
      remaining <= '0;
      cnt_o     <= '0;
      cnt_p     <= '0;
      cnt_q     <= '0;
    end else if (accept) begin
      signature <= SEED;
      remaining <= len;
      cnt_o     <= '0;
      cnt_p     <= '0;
      cnt_q     <= '0;
    end else if (cap) begin
      signature <= {signature[MISR_W-2:0], fb} ^ ins;
      remaining <= remaining - CNT_W'(1);
      if (o && !(&cnt_o)) cnt_o <= cnt_o + CNT_W'(1);
      if (p && !(&cnt_p)) cnt_p <= cnt_p + CNT_W'(1);
      if (q && !(&cnt_q)) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sample_resp_misr.sv
// Bench for sample_resp_misr: randomized runs against a
// vector-list reference of the signature and ones counts.
module tb_sample_resp_misr;

  logic        clk;
  logic        ret;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic        o;
  logic        p;
  logic        q;
  logic        busy;
  logic        done;
  logic [15:0] signature;
  logic [7:0]  cnt_o;
  logic [7:0]  cnt_p;
  logic [7:0]  cnt_q;

  int n_tests;
  int n_fail;
  logic [2:0] vq[$];

  sample_resp_misr dut (
    .clk       (clk),
    .ret       (ret),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .o         (o),
    .p         (p),
    .q         (q),
    .busy      (busy),
    .done      (done),
    .signature (signature),
    .cnt_o     (cnt_o),
    .cnt_p     (cnt_p),
    .cnt_q     (cnt_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_clear(input string tag);
    chk({tag, "_sig"}, signature, 0);
    chk({tag, "_co"}, cnt_o, 0);
    chk({tag, "_cp"}, cnt_p, 0);
    chk({tag, "_cq"}, cnt_q, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // One full window; vectors come from vq when use_q, else random.
  // gap < 0 picks a random number of idle cycles before each vector.
  task automatic run(input int l, input int gap, input bit use_q);
    logic [15:0] es;
    int co, cp, cq, g;
    logic [2:0] v;
    es = 16'hFFFF;
    co = 0;
    cp = 0;
    cq = 0;
    in_valid = 1'b0;
    start = 1'b1;
    len = l[7:0];
    step();
    start = 1'b0;
    len = 8'($urandom);
    chk("busy_after_start", busy, 1);
    for (int i = 0; i < l; i++) begin
      g = (gap >= 0) ? gap : int'($urandom_range(0, 3));
      for (int k = 0; k < g; k++) begin
        in_valid = 1'b0;
        {q, p, o} = 3'($urandom);
        start = 1'($urandom);
        step();
        chk("gap_done", done, 0);
        chk("gap_busy", busy, 1);
      end
      v = use_q ? vq[i] : 3'($urandom);
      in_valid = 1'b1;
      {q, p, o} = v;
      start = 1'($urandom);
      step();
      es = ((es << 1) | 16'($countones(es & 16'hB400) & 1)) ^ {13'd0, v};
      if (co < 255) co += int'(v[0]);
      if (cp < 255) cp += int'(v[1]);
      if (cq < 255) cq += int'(v[2]);
      if (i < l - 1) chk("early_done", done, 0);
    end
    in_valid = 1'b0;
    start = 1'b0;
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 1);
    chk("signature", signature, es);
    chk("cnt_o", cnt_o, co);
    chk("cnt_p", cnt_p, cp);
    chk("cnt_q", cnt_q, cq);
    step();
    chk("done_drop", done, 0);
    chk("busy_drop", busy, 0);
    chk("sig_hold", signature, es);
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    ret = 1'b1;
    start = 1'b0;
    len = 8'd0;
    in_valid = 1'b0;
    {q, p, o} = 3'b000;
    step();
    step();
    ret = 1'b0;
    step();
    chk_clear("reset");

    run(0, 0, 1'b0);
    chk("len0_sig", signature, 32'hFFFF);
    chk("len0_cnt", cnt_o, 0);

    vq = {3'b101};
    run(1, 0, 1'b1);
    chk("len1_sig", signature, 32'hFFFB);
    chk("len1_co", cnt_o, 1);
    chk("len1_cp", cnt_p, 0);
    chk("len1_cq", cnt_q, 1);

    vq = {3'b101, 3'b000};
    run(2, 3, 1'b1);
    chk("len2_sig", signature, 32'hFFF6);

    // idle holds results
    step();
    step();
    chk("idle_hold", signature, 32'hFFF6);

    vq.delete();
    for (int i = 0; i < 255; i++) vq.push_back(3'b111);
    run(255, 0, 1'b1);
    chk("sat_o", cnt_o, 32'hFF);
    run(255, 0, 1'b1);
    chk("sat_q", cnt_q, 32'hFF);

    for (int r = 0; r < 20; r++)
      run(int'($urandom_range(0, 40)), -1, 1'b0);

    // reset mid-run after five vectors
    start = 1'b1;
    len = 8'd20;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      {q, p, o} = 3'($urandom);
      step();
    end
    ret = 1'b1;
    start = 1'b1;
    step();
    ret = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    chk_clear("midreset");
    step();
    chk("midreset_no_done", done, 0);
    chk("midreset_idle", busy, 0);
    run(7, -1, 1'b0);

    // reset beats start in the same cycle
    ret = 1'b1;
    start = 1'b1;
    len = 8'd5;
    step();
    ret = 1'b0;
    start = 1'b0;
    chk("ret_start_busy", busy, 0);
    step();
    chk("ret_start_busy2", busy, 0);
    chk("ret_start_done", done, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
